// File: rtl/bundler_ctrl_if.sv
// Valid/ready hypervector stream.
//   valid : source has a vector on data
//   ready : sink accepts the vector this cycle
//   data  : W-bit hypervector
// master = source side, slave = sink side.
interface bundler_ctrl_if #(
  parameter int unsigned W = 6
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bundler_ctrl.sv
// Sequencer for the bundler: collects NUM_HVS vectors from upstream, pulses
// the bundler, captures its result and offers it downstream. Includes a
// WAIT watchdog, a soft flush and a completed-batch counter.
//   clk, nrst      : clock, async active-low reset
//   flush          : synchronous soft clear
//   in_stream      : upstream vector stream (sink side)
//   bnd_en         : one-cycle bundler start
//   bnd_hv_array   : packed operands, slot 0 = first accepted vector
//   bnd_done       : bundler completion pulse
//   bnd_hv_out     : bundler result
//   res_stream     : downstream result stream (source side)
//   busy           : batch in progress (not idle COLLECT with cnt 0)
//   timeout_err    : sticky watchdog flag
//   batch_count    : completed bundles, wraps
module bundler_ctrl #(
  parameter int unsigned DIMENSIONS = 6,
  parameter int unsigned NUM_HVS    = 5,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            flush,
  bundler_ctrl_if.slave                   in_stream,
  output logic                            bnd_en,
  output logic [NUM_HVS*DIMENSIONS-1:0]   bnd_hv_array,
  input  logic                            bnd_done,
  input  logic [DIMENSIONS-1:0]           bnd_hv_out,
  bundler_ctrl_if.master                  res_stream,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [CNT_W-1:0]                batch_count
);

  localparam int unsigned IDX_W = $clog2(NUM_HVS + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned ARR_W = NUM_HVS * DIMENSIONS;

  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      cnt, cnt_nxt;
  logic [ARR_W-1:0]      arr_nxt;
  logic                  bnd_en_nxt;
  logic                  res_valid, res_valid_nxt;
  logic [DIMENSIONS-1:0] res_hv, res_hv_nxt;
  logic                  timeout_nxt;
  logic                  drop, drop_nxt;
  logic [TMR_W-1:0]      timer, timer_nxt;
  logic [CNT_W-1:0]      batch_nxt;
  logic                  busy_nxt;
  logic                  accept, slot_free, expire;

  // Only combinational output: upstream may push while collecting
  assign in_stream.ready  = nrst && (state == COLLECT) && !flush;
  assign res_stream.valid = res_valid;
  assign res_stream.data  = res_hv;

  assign accept    = in_stream.valid && in_stream.ready;
  // Result slot is free, or the pending result leaves this cycle
  assign slot_free = !res_valid || res_stream.ready;
  assign expire    = (timer == TMR_W'(TIMEOUT - 1));

  // Next-state and register updates
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    arr_nxt       = bnd_hv_array;
    bnd_en_nxt    = 1'b0;
    res_valid_nxt = res_valid && !res_stream.ready;
    res_hv_nxt    = res_hv;
    timeout_nxt   = timeout_err;
    drop_nxt      = drop;
    timer_nxt     = timer;
    batch_nxt     = batch_count;

    case (state)
      COLLECT: begin
        if (flush) begin
          cnt_nxt = '0;
          arr_nxt = '0;
        end else if (accept) begin
          arr_nxt[DIMENSIONS*int'(cnt) +: DIMENSIONS] = in_stream.data;
          cnt_nxt = cnt + IDX_W'(1);
          if (cnt == IDX_W'(NUM_HVS - 1)) state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (flush) begin
          cnt_nxt   = '0;
          arr_nxt   = '0;
          state_nxt = COLLECT;
        end else if (slot_free) begin
          bnd_en_nxt = 1'b1;
          timer_nxt  = '0;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        timer_nxt = timer + TMR_W'(1);
        if (bnd_done || expire) begin
          state_nxt = COLLECT;
          cnt_nxt   = '0;
          drop_nxt  = 1'b0;
          // A flush in the same cycle discards the result or the timeout
          if (bnd_done) begin
            if (!flush && !drop) begin
              res_hv_nxt    = bnd_hv_out;
              res_valid_nxt = 1'b1;
              batch_nxt     = batch_count + CNT_W'(1);
            end
          end else if (!flush) begin
            timeout_nxt = 1'b1;
          end
        end else if (flush) begin
          // Bundler keeps running; its result is swallowed on completion
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = COLLECT;
    endcase

    if (flush) begin
      res_valid_nxt = 1'b0;
      timeout_nxt   = 1'b0;
    end

    busy_nxt = (state_nxt != COLLECT) || (cnt_nxt != '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= COLLECT;
      cnt          <= '0;
      bnd_hv_array <= '0;
      bnd_en       <= 1'b0;
      res_valid    <= 1'b0;
      res_hv       <= '0;
      timeout_err  <= 1'b0;
      drop         <= 1'b0;
      timer        <= '0;
      batch_count  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bnd_hv_array <= arr_nxt;
      bnd_en       <= bnd_en_nxt;
      res_valid    <= res_valid_nxt;
      res_hv       <= res_hv_nxt;
      timeout_err  <= timeout_nxt;
      drop         <= drop_nxt;
      timer        <= timer_nxt;
      batch_count  <= batch_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_bundler_ctrl.sv
// Testbench for bundler_ctrl with a behavioural majority bundler and a
// result scoreboard. Inputs change 1 ns after posedge, outputs sampled at negedge.
module tb_bundler_ctrl;

  localparam int unsigned D   = 6;
  localparam int unsigned N   = 5;
  localparam int unsigned ARR = N * D;
  localparam int unsigned TO  = 8;
  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 16;

  logic           clk = 1'b0;
  logic           nrst;
  logic           flush;
  logic           bnd_en;
  logic [ARR-1:0] bnd_hv_array;
  logic           bnd_done;
  logic [D-1:0]   bnd_hv_out;
  logic           busy;
  logic           timeout_err;
  logic [CW-1:0]  batch_count;

  bundler_ctrl_if #(.W(D)) in_if ();
  bundler_ctrl_if #(.W(D)) res_if ();

  bundler_ctrl #(.DIMENSIONS(D), .NUM_HVS(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .flush        (flush),
    .in_stream    (in_if),
    .bnd_en       (bnd_en),
    .bnd_hv_array (bnd_hv_array),
    .bnd_done     (bnd_done),
    .bnd_hv_out   (bnd_hv_out),
    .res_stream   (res_if),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .batch_count  (batch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int exp_batches = 0;
  logic [D-1:0] exp_q[$];
  bit stall = 1'b0;

  typedef struct {
    logic [ARR-1:0] vecs;  // slot 0 in the low bits, same layout as bnd_hv_array
    bit             gaps;
    bit             bp;
    logic [D-1:0]   exp;
  } row_t;
  row_t tbl[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [D-1:0] maj(input logic [ARR-1:0] a);
    logic [D-1:0] r;
    int c;
    for (int b = 0; b < int'(D); b++) begin
      c = 0;
      for (int i = 0; i < int'(N); i++) c += int'(a[i*D + b]);
      r[b] = (c > int'(N) / 2);
    end
    return r;
  endfunction

  // Behavioural bundler: fixed latency, majority per bit
  logic [ARR-1:0] m_arr;
  int             m_lat;
  bit             m_run;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_run <= 1'b0; m_lat <= 0; m_arr <= '0;
      bnd_done <= 1'b0; bnd_hv_out <= '0;
    end else begin
      bnd_done <= 1'b0;
      if (bnd_en) begin
        m_run <= 1'b1; m_lat <= int'(LAT); m_arr <= bnd_hv_array;
      end else if (m_run) begin
        if (m_lat == 1) begin
          m_run <= 1'b0;
          if (!stall) begin
            bnd_done   <= 1'b1;
            bnd_hv_out <= maj(m_arr);
          end
        end else begin
          m_lat <= m_lat - 1;
        end
      end
    end
  end

  // Scoreboard: compare each delivered result with the oldest expectation
  always @(negedge clk) begin
    if (nrst && res_if.valid && res_if.ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got %0h with no result expected at %0t", res_if.data, $time);
      end else begin
        chk("res_hv", 64'(res_if.data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [D-1:0] hv, output bit first);
    int t;
    bit acc;
    t = 0; acc = 1'b0; first = 1'b0;
    in_if.valid = 1'b1;
    in_if.data  = hv;
    while (!acc && t < 40) begin
      @(negedge clk);
      if (in_if.ready) begin
        acc = 1'b1;
        if (t == 0) first = 1'b1;
      end
      tick();
      t++;
    end
    in_if.valid = 1'b0;
    chk("accept", 64'(acc), 64'(1));
  endtask

  // Called right after the completing accept with the result slot free
  task automatic check_launch(input logic [ARR-1:0] vecs);
    @(negedge clk);
    chk("launch_not_early", 64'(bnd_en), 64'(0));
    tick();
    @(negedge clk);
    chk("launch_en", 64'(bnd_en), 64'(1));
    chk("launch_array", 64'(bnd_hv_array), 64'(vecs));
    tick();
    @(negedge clk);
    chk("launch_one_pulse", 64'(bnd_en), 64'(0));
  endtask

  task automatic run_batch(input logic [ARR-1:0] vecs, input bit gaps, input logic [D-1:0] exp,
                           input bit push, input bit launch, output bit all_first);
    bit f;
    all_first = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      send(vecs[i*D +: D], f);
      all_first &= f;
      if (gaps && i < int'(N) - 1) tick();
    end
    if (push) begin
      exp_q.push_back(exp);
      exp_batches++;
    end
    if (launch) check_launch(vecs);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 80) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!res_if.valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("result_pending", 64'(res_if.valid), 64'(1));
  endtask

  initial begin
    bit f;
    bit seen;
    logic [ARR-1:0] rv;

    tbl[0] = '{vecs: {6'b100011, 6'b100011, 6'b001111, 6'b000111, 6'b001101},
               gaps: 1'b0, bp: 1'b0, exp: 6'b000111};
    tbl[1] = '{vecs: {6'b000100, 6'b010100, 6'b001000, 6'b010000, 6'b000010},
               gaps: 1'b0, bp: 1'b1, exp: 6'b000000};
    tbl[2] = '{vecs: {6'b110101, 6'b010111, 6'b001111, 6'b011011, 6'b111011},
               gaps: 1'b1, bp: 1'b0, exp: 6'b011111};

    nrst = 1'b1; flush = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; res_if.ready = 1'b1;
    #2 nrst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 64'(in_if.ready), 64'(0));
    chk("rst_bnd_en", 64'(bnd_en), 64'(0));
    chk("rst_array", 64'(bnd_hv_array), 64'(0));
    chk("rst_res_valid", 64'(res_if.valid), 64'(0));
    chk("rst_res_hv", 64'(res_if.data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_timeout", 64'(timeout_err), 64'(0));
    chk("rst_batch", 64'(batch_count), 64'(0));
    tick();
    nrst = 1'b1;

    // Table: basic, back-pressure, upstream gaps
    for (int r = 0; r < 3; r++) begin
      tick();
      if (tbl[r].bp) begin
        res_if.ready = 1'b0;
        run_batch(tbl[0].vecs, 1'b0, tbl[0].exp, 1'b1, 1'b1, f);
        wait_valid();
        tick();
        run_batch(tbl[r].vecs, tbl[r].gaps, tbl[r].exp, 1'b1, 1'b0, f);
        chk("bp_in_ready", 64'(f), 64'(1));
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_hold_no_en", 64'(bnd_en), 64'(0));
          chk("bp_hold_valid", 64'(res_if.valid), 64'(1));
          tick();
        end
        res_if.ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_launch_en", 64'(bnd_en), 64'(1));
        chk("bp_launch_array", 64'(bnd_hv_array), 64'(tbl[r].vecs));
      end else begin
        run_batch(tbl[r].vecs, tbl[r].gaps, tbl[r].exp, 1'b1, 1'b1, f);
      end
      wait_drain();
      tick();
      @(negedge clk);
      chk("res_valid_one_cycle", 64'(res_if.valid), 64'(0));
      chk("batch_count", 64'(batch_count), 64'(exp_batches));
    end

    // Timeout: bundler never answers
    stall = 1'b1;
    tick();
    for (int i = 0; i < int'(N); i++) rv[i*D +: D] = D'($urandom);
    run_batch(rv, 1'b0, '0, 1'b0, 1'b1, f);
    for (int k = 2; k <= int'(TO); k++) begin
      tick();
      @(negedge clk);
      chk("timeout_edge", 64'(timeout_err), 64'(k == int'(TO)));
    end
    chk("timeout_no_result", 64'(res_if.valid), 64'(0));
    chk("timeout_in_ready", 64'(in_if.ready), 64'(1));
    chk("timeout_batch", 64'(batch_count), 64'(exp_batches));
    stall = 1'b0;
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks_ready", 64'(in_if.ready), 64'(0));
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_clears_timeout", 64'(timeout_err), 64'(0));
    chk("flush_clears_array", 64'(bnd_hv_array), 64'(0));

    // Flush while the bundler is running
    tick();
    for (int i = 0; i < int'(N); i++) rv[i*D +: D] = D'($urandom);
    run_batch(rv, 1'b0, '0, 1'b0, 1'b1, f);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen |= res_if.valid;
      tick();
    end
    @(negedge clk);
    chk("flush_wait_no_result", 64'(seen), 64'(0));
    chk("flush_wait_batch", 64'(batch_count), 64'(exp_batches));
    chk("flush_wait_idle", 64'(busy), 64'(0));
    tick();
    for (int i = 0; i < int'(N); i++) rv[i*D +: D] = D'($urandom);
    run_batch(rv, 1'b0, maj(rv), 1'b1, 1'b1, f);
    wait_drain();
    tick();
    @(negedge clk);
    chk("after_flush_batch", 64'(batch_count), 64'(exp_batches));

    // Async reset mid-collection
    tick();
    for (int i = 0; i < 3; i++) send(D'($urandom), f);
    in_if.valid = 1'b1;
    #2 nrst = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_if.ready), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_array", 64'(bnd_hv_array), 64'(0));
    chk("arst_batch", 64'(batch_count), 64'(0));
    chk("arst_res_valid", 64'(res_if.valid), 64'(0));
    exp_batches = 0;
    tick();
    in_if.valid = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    for (int i = 0; i < int'(N); i++) rv[i*D +: D] = D'($urandom);
    for (int i = 0; i < int'(N) - 1; i++) send(rv[i*D +: D], f);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_need_full_batch", 64'(bnd_en), 64'(0));
      chk("arst_busy_partial", 64'(busy), 64'(1));
      tick();
    end
    send(rv[(N-1)*D +: D], f);
    exp_q.push_back(maj(rv));
    exp_batches++;
    check_launch(rv);
    wait_drain();
    tick();
    @(negedge clk);
    chk("arst_batch_after", 64'(batch_count), 64'(exp_batches));

    // Random batches
    for (int b = 0; b < 3; b++) begin
      tick();
      for (int i = 0; i < int'(N); i++) rv[i*D +: D] = D'($urandom);
      run_batch(rv, 1'($urandom_range(0, 1)), maj(rv), 1'b1, 1'b1, f);
      wait_drain();
    end
    tick();
    @(negedge clk);
    chk("final_batch", 64'(batch_count), 64'(exp_batches));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
